// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one combined memory port
// Optional misalignment error checking enabled by defining MEM_ALIGN_CHECK_EN.
module mem_arbiter #(
    parameter int MEM_WORDS    = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);
    localparam logic [3:0]  STARVE_MAX  = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        src_d_q, src_d_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        fetch_win, data_win, err_now;

    // Data has priority unless the fetch side has waited STARVE_LIMIT data grants.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (if_req && (!d_req || starve_q == STARVE_MAX)) begin
                fetch_win = 1'b1;
            end else if (d_req) begin
                data_win = 1'b1;
            end
        end
    end

    always_comb begin
        err_now = (addr_q[31:2] >= MEM_WORDS_W);
`ifdef MEM_ALIGN_CHECK_EN
        if (addr_q[1:0] != 2'b00) begin
            err_now = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        src_d_d    = src_d_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_we     = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        d_err      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_win) begin
                    state_d  = ACCESS;
                    addr_d   = if_addr;
                    wdata_d  = 32'h0;
                    we_d     = 1'b0;
                    src_d_d  = 1'b0;
                    starve_d = 4'd0;
                end else if (data_win) begin
                    state_d = ACCESS;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    src_d_d = 1'b1;
                    if (if_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ACCESS: begin
                state_d   = RESP;
                mem_addr  = addr_q & 32'hFFFF_FFFC;
                mem_wdata = wdata_q;
                mem_we    = we_q && !err_now && !reset;
                err_d     = err_now;
                if (src_d_q) begin
                    d_rdata_d = (we_q || err_now) ? 32'h0 : mem_rdata;
                end else begin
                    if_rdata_d = err_now ? 32'h0 : mem_rdata;
                end
            end
            RESP: begin
                state_d   = IDLE;
                if_rvalid = !src_d_q && !reset;
                d_rvalid  = src_d_q && !reset;
                d_err     = src_d_q && err_q && !reset;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            src_d_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            src_d_q    <= src_d_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_gnt   = fetch_win;
    assign d_gnt    = data_win;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (STARVE_LIMIT=2)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tb_mem [0:63];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit          is_d;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];

    mem_arbiter #(.MEM_WORDS(64), .STARVE_LIMIT(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = tb_mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes or writes.
    always @(negedge clk) begin
        resp_t e;
        wr_t   w;
        chk("gnt_exclusive", {31'b0, if_gnt && d_gnt}, 32'd0);
        chk("mem_addr_aligned", {30'b0, mem_addr[1:0]}, 32'd0);
        if (if_rvalid || d_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                chk("resp_src", {31'b0, d_rvalid}, {31'b0, e.is_d});
                chk("resp_cycle", cyc, e.cyc);
                if (d_rvalid) begin
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_err", {31'b0, d_err}, {31'b0, e.err});
                end else begin
                    chk("if_rdata", if_rdata, e.rdata);
                end
            end
        end
        if (rq.size() > 0 && rq[0].cyc < cyc) begin
            e = rq.pop_front();
            chk("missing_rvalid", 32'd0, 32'd1);
        end
        if (mem_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_mem_we", 32'd1, 32'd0);
            end else begin
                w = wq.pop_front();
                chk("wr_cycle", cyc, w.cyc);
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_wdata, w.data);
            end
        end
        if (wq.size() > 0 && wq[0].cyc < cyc) begin
            w = wq.pop_front();
            chk("missing_mem_we", 32'd0, 32'd1);
        end
    end

    task automatic wait_gnt(output logic is_d, output int t);
        int n = 0;
        is_d = 1'b0;
        t = -1;
        while (n < 20 && t < 0) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                is_d = d_gnt;
                t = cyc;
            end
            n++;
        end
        if (t < 0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_wr, input logic [31:0] exp_rdata, input logic exp_err);
        logic is_d;
        int   t;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        wait_gnt(is_d, t);
        chk("d_gnt_side", {31'b0, is_d}, 32'd1);
        if (t >= 0) begin
            if (exp_wr) wq.push_back('{t + 1, addr & 32'hFFFF_FFFC, wdata});
            rq.push_back('{1'b1, t + 2, exp_rdata, exp_err});
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic f_access(input logic [31:0] addr, input logic [31:0] exp_rdata);
        logic is_d;
        int   t;
        if_req = 1'b1; if_addr = addr;
        wait_gnt(is_d, t);
        chk("if_gnt_side", {31'b0, is_d}, 32'd0);
        if (t >= 0) rq.push_back('{1'b0, t + 2, exp_rdata, 1'b0});
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        is_d;
        int          t, last_t;
        logic [5:0]  order;
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h1000_0000 + i;
        tb_mem[0] = 32'h8C01_0088;
        reset = 1'b1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
            chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
            chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

        d_access(1'b1, 32'h10, 32'h0000_000F, 1'b1, 32'h0, 1'b0);
        f_access(32'h0, 32'h8C01_0088);
        d_access(1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_000F, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        d_access(1'b0, 32'h12, 32'h0, 1'b0, 32'h0, 1'b1);
`else
        d_access(1'b0, 32'h12, 32'h0, 1'b0, 32'h0000_000F, 1'b0);
`endif
        d_access(1'b1, 32'h100, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        f_access(32'h100, 32'h0);

        // Both sides held: with STARVE_LIMIT=2 expect D, D, IF, D, D, IF.
        order = 6'b110110;
        last_t = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h4;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(is_d, t);
            chk("starve_order", {31'b0, is_d}, {31'b0, order[5 - k]});
            if (last_t >= 0) chk("grant_spacing", t - last_t, 32'd3);
            if (t >= 0) begin
                if (is_d) rq.push_back('{1'b1, t + 2, 32'h1000_0008, 1'b0});
                else      rq.push_back('{1'b0, t + 2, 32'h1000_0001, 1'b0});
            end
            last_t = t;
            @(posedge clk);
        end
        #1;
        d_req = 1'b0; if_req = 1'b0;

        // Reset during the ACCESS cycle of a store discards it entirely.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h8;
        wait_gnt(is_d, t);
        chk("rst_mid_d_gnt", {31'b0, is_d}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("starve_before_rst", {28'b0, dut.starve_q}, 32'd1);
        chk("rst_access_mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_state_idle", 32'(dut.state_q), 32'd0);
        chk("post_rst_starve", {28'b0, dut.starve_q}, 32'd0);
        chk("post_rst_d_rdata", d_rdata, 32'd0);
        chk("post_rst_if_rdata", if_rdata, 32'd0);
        repeat (5) @(negedge clk);
        chk("mem_0x30_untouched", tb_mem[12], 32'h1000_000C);
        chk("mem_0x10_stored", tb_mem[4], 32'h0000_000F);
        chk("resp_queue_empty", rq.size(), 32'd0);
        chk("write_queue_empty", wq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
